// File: rtl/frame_pkg.sv
// Shared types and default geometry for the frame scan counter.
// The optional completed-frame counter is enabled by FRAME_SCAN_FRAME_CNT_EN.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEFAULT_H_COUNT = 32;
  localparam int DEFAULT_V_COUNT = 24;
  localparam int DEFAULT_FRAME_W = 8;

endpackage

// File: rtl/frame_scan_counter_if.sv
// Control and position bus between a scan controller and the counter.
// frame_cnt exists only when FRAME_SCAN_FRAME_CNT_EN is defined.
interface frame_scan_counter_if
  import frame_pkg::*;
#(
  parameter int H_COUNT = DEFAULT_H_COUNT,
  parameter int V_COUNT = DEFAULT_V_COUNT,
  parameter int FRAME_W = DEFAULT_FRAME_W
);

  localparam int X_W = $clog2(H_COUNT);
  localparam int Y_W = $clog2(V_COUNT);

  logic           enb;
  logic           pix_valid;
  logic           frame_ack;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           newLine;
  logic           endFrame;
  logic           busy;
`ifdef FRAME_SCAN_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;
`endif

  modport master (
    output enb,
    output pix_valid,
    output frame_ack,
`ifdef FRAME_SCAN_FRAME_CNT_EN
    input  frame_cnt,
`endif
    input  x,
    input  y,
    input  newLine,
    input  endFrame,
    input  busy
  );

  modport slave (
    input  enb,
    input  pix_valid,
    input  frame_ack,
`ifdef FRAME_SCAN_FRAME_CNT_EN
    output frame_cnt,
`endif
    output x,
    output y,
    output newLine,
    output endFrame,
    output busy
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter with a synchronous clear.
// wrap flags the increment that rolls the count from MAX-1 back to 0.
module wrap_counter #(
  parameter int MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clr,
  output logic [$clog2(MAX)-1:0] value,
  output logic                   wrap
);

  localparam int W = $clog2(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign wrap = inc && (value == LAST);

  // Count accepted increments, rolling over at MAX-1; clear wins over inc.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/frame_scan_counter.sv
// Raster position counter: walks x across each line and y down each frame,
// then holds at end of frame until acknowledged.
// Define FRAME_SCAN_FRAME_CNT_EN to add the completed-frame counter.
module frame_scan_counter
  import frame_pkg::*;
#(
  parameter int H_COUNT = DEFAULT_H_COUNT,
  parameter int V_COUNT = DEFAULT_V_COUNT,
  parameter int FRAME_W = DEFAULT_FRAME_W
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_scan_counter_if.slave  bus
);

  localparam int X_W = $clog2(H_COUNT);
  localparam int Y_W = $clog2(V_COUNT);

  state_t         state;
  logic           scan_active;
  logic           x_inc;
  logic           x_wrap;
  logic           y_wrap;
  logic           frame_done;
  logic [X_W-1:0] x_value;
  logic [Y_W-1:0] y_value;
  logic           new_line;
  logic           end_frame;
  logic           busy_q;
`ifdef FRAME_SCAN_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q;
`endif

  // Counters only move while scanning with enable high; anywhere else they
  // are held cleared, which also covers the enb-drop and HOLD cases.
  assign scan_active = (state == SCAN) && bus.enb;
  assign x_inc       = scan_active && bus.pix_valid;
  assign frame_done  = x_wrap && y_wrap;

  wrap_counter #(.MAX(H_COUNT)) x_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (x_inc),
    .clr   (!scan_active),
    .value (x_value),
    .wrap  (x_wrap)
  );

  wrap_counter #(.MAX(V_COUNT)) y_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (x_wrap),
    .clr   (!scan_active),
    .value (y_value),
    .wrap  (y_wrap)
  );

  // Scan FSM with registered newLine/endFrame/busy (and frame count).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      new_line  <= 1'b0;
      end_frame <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FRAME_SCAN_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          new_line  <= 1'b0;
          end_frame <= 1'b0;
          if (bus.enb) begin
            state  <= SCAN;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SCAN: begin
          if (!bus.enb) begin
            state     <= IDLE;
            new_line  <= 1'b0;
            end_frame <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            new_line <= x_wrap;
            if (frame_done) begin
              state     <= HOLD;
              end_frame <= 1'b1;
              busy_q    <= 1'b0;
`ifdef FRAME_SCAN_FRAME_CNT_EN
              frame_cnt_q <= frame_cnt_q + 1'b1;
`endif
            end else begin
              busy_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          new_line <= 1'b0;
          if (!bus.enb) begin
            state     <= IDLE;
            end_frame <= 1'b0;
            busy_q    <= 1'b0;
          end else if (bus.frame_ack) begin
            state     <= SCAN;
            end_frame <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          new_line  <= 1'b0;
          end_frame <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x        = x_value;
  assign bus.y        = y_value;
  assign bus.newLine  = new_line;
  assign bus.endFrame = end_frame;
  assign bus.busy     = busy_q;
`ifdef FRAME_SCAN_FRAME_CNT_EN
  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_frame_scan_counter.sv
// Testbench for frame_scan_counter with a 4x3 frame and a 2-bit frame counter.
// Frame-counter checks are compiled in only with FRAME_SCAN_FRAME_CNT_EN.
module tb_frame_scan_counter;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int FW = 2;
  localparam int XW = 2;
  localparam int YW = 2;
`ifdef FRAME_SCAN_FRAME_CNT_EN
  localparam int OUT_W = 7 + FW;
`else
  localparam int OUT_W = 7;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  // Reference model: linear pixel index within the frame plus mode flags.
  int m_pix    = 0;
  bit m_scan   = 0;
  bit m_hold   = 0;
  bit m_nl     = 0;
  int m_frames = 0;

  frame_scan_counter_if #(.H_COUNT(H), .V_COUNT(V), .FRAME_W(FW)) bus ();

  frame_scan_counter #(.H_COUNT(H), .V_COUNT(V), .FRAME_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] observed();
    observed = {bus.x, bus.y, bus.newLine, bus.endFrame, bus.busy
`ifdef FRAME_SCAN_FRAME_CNT_EN
                , bus.frame_cnt
`endif
               };
  endfunction

  function automatic logic [OUT_W-1:0] expected();
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    ex = XW'(m_pix % H);
    ey = YW'(m_pix / H);
    expected = {ex, ey, m_nl, m_hold, m_scan
`ifdef FRAME_SCAN_FRAME_CNT_EN
                , FW'(m_frames % (1 << FW))
`endif
               };
  endfunction

  task automatic model_step(input logic r, input logic e, input logic p, input logic a);
    if (r) begin
      m_scan = 0; m_hold = 0; m_pix = 0; m_nl = 0; m_frames = 0;
    end else if (!m_scan && !m_hold) begin
      m_nl = 0;
      if (e) m_scan = 1;
    end else if (!e) begin
      m_scan = 0; m_hold = 0; m_pix = 0; m_nl = 0;
    end else if (m_hold) begin
      m_nl = 0;
      if (a) begin
        m_hold = 0; m_scan = 1;
      end
    end else begin
      m_nl = 0;
      if (p) begin
        m_pix = m_pix + 1;
        if (m_pix % H == 0) m_nl = 1;
        if (m_pix == H * V) begin
          m_pix = 0; m_scan = 0; m_hold = 1;
          m_frames = (m_frames + 1) % (1 << FW);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic p, input logic a);
    rst           = r;
    bus.enb       = e;
    bus.pix_valid = p;
    bus.frame_ack = a;
    @(posedge clk);
    model_step(r, e, p, a);
    #1;
  endtask

  task automatic test_reset();
    logic [OUT_W-1:0] o;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      o = observed();
      checks++;
      if (o !== '0) $display("[TB] FAIL reset_state: got %h, expected %h", o, {OUT_W{1'b0}});
      else passed++;
    end
  endtask

  task automatic test_full_frame();
    int nl_count = 0;
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] e;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) $display("[TB] FAIL enter_scan_busy: got %b, expected 1", bus.busy);
    else passed++;
    for (int i = 1; i <= H * V; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      if (bus.newLine === 1'b1) nl_count++;
      o = observed(); e = expected();
      checks++;
      if (o !== e) $display("[TB] FAIL full_frame_px%0d: got %h, expected %h", i, o, e);
      else passed++;
      if (i == H * V - 1) begin
        checks++;
        if (bus.endFrame !== 1'b0) $display("[TB] FAIL endframe_early: got %b, expected 0", bus.endFrame);
        else passed++;
      end
    end
    checks++;
    if ({bus.endFrame, bus.x, bus.y} !== {1'b1, 2'd0, 2'd0})
      $display("[TB] FAIL endframe_at_12: got ef=%b x=%0d y=%0d, expected ef=1 x=0 y=0",
               bus.endFrame, bus.x, bus.y);
    else passed++;
    checks++;
    if (nl_count != V) $display("[TB] FAIL newline_count: got %0d, expected %0d", nl_count, V);
    else passed++;
  endtask

  task automatic test_hold();
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] e;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      o = observed(); e = expected();
      checks++;
      if (o !== e || bus.endFrame !== 1'b1 || bus.x !== '0 || bus.y !== '0)
        $display("[TB] FAIL hold_cycle%0d: got %h, expected %h", i, o, e);
      else passed++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({bus.endFrame, bus.busy} !== 2'b01)
      $display("[TB] FAIL hold_ack: got ef=%b busy=%b, expected ef=0 busy=1", bus.endFrame, bus.busy);
    else passed++;
  endtask

  task automatic test_toggle_valid();
    int accepted = 0;
    int nl_count = 0;
    logic p;
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] e;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      p = 1'(i % 2);
      if (p) accepted++;
      applyStimulus(1'b0, 1'b1, p, 1'b0);
      if (bus.newLine === 1'b1) nl_count++;
      o = observed(); e = expected();
      checks++;
      if (o !== e) $display("[TB] FAIL toggle_cycle%0d: got %h, expected %h", i, o, e);
      else passed++;
    end
    checks++;
    if (nl_count != accepted / H)
      $display("[TB] FAIL toggle_newlines: got %0d, expected %0d", nl_count, accepted / H);
    else passed++;
  endtask

  task automatic test_enb_drop();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y} !== {2'd2, 2'd1})
      $display("[TB] FAIL pre_drop_pos: got x=%0d y=%0d, expected x=2 y=1", bus.x, bus.y);
    else passed++;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y, bus.busy, bus.newLine, bus.endFrame} !== '0)
      $display("[TB] FAIL enb_drop_idle: got x=%0d y=%0d busy=%b, expected all 0", bus.x, bus.y, bus.busy);
    else passed++;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y, bus.busy} !== {2'd1, 2'd0, 1'b1})
      $display("[TB] FAIL restart_pos: got x=%0d y=%0d busy=%b, expected x=1 y=0 busy=1",
               bus.x, bus.y, bus.busy);
    else passed++;
  endtask

  task automatic test_reset_in_hold();
    logic [OUT_W-1:0] o;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < H * V; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.endFrame !== 1'b1) $display("[TB] FAIL reach_hold: got %b, expected 1", bus.endFrame);
    else passed++;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    o = observed();
    checks++;
    if (o !== '0) $display("[TB] FAIL reset_in_hold: got %h, expected %h", o, {OUT_W{1'b0}});
    else passed++;
  endtask

  task automatic test_random();
    logic r, e, p, a;
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] ex;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(63) == 0);
      e = ($urandom_range(15) != 0);
      p = 1'($urandom);
      a = ($urandom_range(3) == 0);
      applyStimulus(r, e, p, a);
      o = observed(); ex = expected();
      checks++;
      if (o !== ex) $display("[TB] FAIL random_cycle%0d: got %h, expected %h", i, o, ex);
      else passed++;
    end
  endtask

`ifdef FRAME_SCAN_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < H * V; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.frame_cnt !== FW'(exp_seq[f]))
        $display("[TB] FAIL frame_cnt_%0d: got %0d, expected %0d", f, bus.frame_cnt, exp_seq[f]);
      else passed++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.frame_cnt !== 2'd1)
      $display("[TB] FAIL frame_cnt_after_enb_drop: got %0d, expected 1", bus.frame_cnt);
    else passed++;
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.enb       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.frame_ack = 1'b0;
    test_reset();
    test_full_frame();
    test_hold();
    test_toggle_valid();
    test_enb_drop();
    test_reset_in_hold();
`ifdef FRAME_SCAN_FRAME_CNT_EN
    test_frame_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/frame_scan_counter.md
FRAME_SCAN_COUNTER -- requirements
Module: frame_scan_counter

Interface
REQ-001 The block SHALL have parameter H_COUNT, default 32, meaning pixels per line (legal range 2..4096).
REQ-002 The block SHALL have parameter V_COUNT, default 24, meaning lines per frame (legal range 2..4096).
REQ-003 The block SHALL have parameter FRAME_W, default 8, meaning frame-counter width in bits.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-007 The block SHALL have port enb, input, 1 bit, the active-high scan enable.
REQ-008 The block SHALL have port pix_valid, input, 1 bit, which advances the position by one pixel.
REQ-009 The block SHALL have port frame_ack, input, 1 bit, which releases the end-of-frame hold.
REQ-010 The block SHALL have port x, output, $clog2(H_COUNT) bits, the current pixel column.
REQ-011 The block SHALL have port y, output, $clog2(V_COUNT) bits, the current line.
REQ-012 The block SHALL have port newLine, output, 1 bit, a one-cycle end-of-line pulse.
REQ-013 The block SHALL have port endFrame, output, 1 bit, the end-of-frame level, held until acknowledged.
REQ-014 The block SHALL have port busy, output, 1 bit, which is high in SCAN.
REQ-015 The block SHALL have port frame_cnt, output, FRAME_W bits, the number of completed frames (present only with FRAME_CNT_EN).

Function
REQ-016 The FSM SHALL have states IDLE, SCAN and HOLD; all outputs SHALL be registered.
REQ-017 In IDLE, x, y, newLine and endFrame SHALL be 0; enb=1 SHALL move the FSM to SCAN on the next edge.
REQ-018 In SCAN, pix_valid=1 SHALL increment x by 1; pix_valid=0 SHALL hold x and y.
REQ-019 In SCAN, pix_valid=1 with x==H_COUNT-1 SHALL set x to 0, increment y and pulse newLine high for exactly one cycle.
REQ-020 In SCAN, pix_valid=1 with x==H_COUNT-1 and y==V_COUNT-1 SHALL set x and y to 0, pulse newLine, set endFrame to 1 and move to HOLD, all on the same edge.
REQ-021 In HOLD, endFrame SHALL stay 1, pix_valid SHALL be ignored, and x and y SHALL stay 0.
REQ-022 In HOLD, frame_ack=1 SHALL clear endFrame on the next edge and move to SCAN if enb=1, otherwise to IDLE.
REQ-023 frame_ack outside HOLD SHALL have no effect.
REQ-024 enb=0 in SCAN or HOLD SHALL move to IDLE on the next edge, clear x, y, newLine and endFrame, and SHALL take priority over pix_valid and frame_ack.
REQ-025 busy SHALL equal 1 exactly while the state is SCAN.
REQ-026 Counter arithmetic SHALL be unsigned; x and y SHALL never exceed H_COUNT-1 and V_COUNT-1 respectively.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, with x=0, y=0, newLine=0, endFrame=0, busy=0 and frame_cnt=0.
REQ-028 rst SHALL take priority over every other input, including a reset asserted mid-line or in HOLD.

Configuration
REQ-029 With macro FRAME_SCAN_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 on each SCAN-to-HOLD transition and wrap from 2^FRAME_W-1 to 0.
REQ-030 enb=0 SHALL NOT clear frame_cnt; only rst clears it.
REQ-031 Without FRAME_SCAN_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 The state enum (IDLE/SCAN/HOLD) and the default H_COUNT/V_COUNT constants SHALL live in the shared package frame_pkg.
REQ-033 One sub-module, wrap_counter (parameter MAX, inputs inc/clr, outputs value and wrap), SHALL be instantiated twice, once for x and once for y.

Verification
REQ-034 H=4, V=3: rst, enb=1, pix_valid held at 1 -> newLine high on the edges where x wraps at 3; endFrame rises on the 12th accepted pixel; x=y=0.
REQ-035 In HOLD with pix_valid=1 for 5 cycles -> x, y unchanged and endFrame stays 1; frame_ack=1 -> endFrame=0 next cycle and busy=1.
REQ-036 pix_valid toggled every other cycle -> x advances only on valid cycles; newLine occurs once per 4 accepted pixels.
REQ-037 enb dropped at x=2, y=1 -> next cycle IDLE, x=y=0; re-enable -> scanning restarts from 0,0.
REQ-038 rst asserted in HOLD at the same cycle as frame_ack -> IDLE with all outputs 0.
REQ-039 FRAME_SCAN_FRAME_CNT_EN with FRAME_W=2 and 5 frames completed -> frame_cnt sequence 1,2,3,0,1.
